// File: rtl/jtframe_ram_fifo_ctl.sv
// rtl/jtframe_ram_fifo_ctl.sv - FWFT FIFO controller around a dual-port RAM with registered read data
module jtframe_ram_fifo_ctl #(
  parameter int dw = 8,
  parameter int aw = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [dw-1:0] din,
  input  logic          wr,
  output logic          full,
  input  logic          rd,
  output logic [dw-1:0] dout,
  output logic          empty,
  output logic [aw+1:0] level,
  output logic          ovf,
  output logic          unf,
  output logic [aw-1:0] ram_addr0,
  output logic [dw-1:0] ram_data0,
  output logic          ram_we0,
  output logic [aw-1:0] ram_addr1,
  input  logic [dw-1:0] ram_q1
);

  logic [aw:0]   wr_ptr_q, wr_ptr_d;
  logic [aw:0]   rd_ptr_q, rd_ptr_d;
  logic          inflight_q, inflight_d;
  logic [1:0]    out_cnt_q, out_cnt_d;
  logic [dw-1:0] dout_q, dout_d;
  logic [dw-1:0] skid_q, skid_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic [aw:0]   ram_cnt;
  logic [2:0]    occ;
  logic          push, pop, fetch;

  assign ram_cnt = wr_ptr_q - rd_ptr_q;
  assign full    = (ram_cnt == {1'b1, {aw{1'b0}}});
  assign empty   = (out_cnt_q == 2'd0);
  assign push    = wr & ~full & ~flush;
  assign pop     = rd & ~empty;

  // Output-stage slots already claimed, counting the word still coming out of the RAM
  assign occ   = {1'b0, out_cnt_q} + {2'b00, inflight_q};
  assign fetch = (ram_cnt != '0) && (occ < (3'd2 + {2'b00, pop})) && !flush;

  assign ram_addr0 = wr_ptr_q[aw-1:0];
  assign ram_data0 = din;
  assign ram_we0   = push;
  assign ram_addr1 = rd_ptr_q[aw-1:0];

  assign dout  = dout_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign level = {1'b0, ram_cnt} + {{aw{1'b0}}, out_cnt_q} + {{(aw+1){1'b0}}, inflight_q};

  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{aw{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{aw{1'b0}}, fetch};
    inflight_d = fetch;
    out_cnt_d  = out_cnt_q;
    dout_d     = dout_q;
    skid_d     = skid_q;
    ovf_d      = ovf_q | (wr & full & ~flush);
    unf_d      = unf_q | (rd & empty & ~flush);

    if (flush) begin
      rd_ptr_d   = wr_ptr_q;
      inflight_d = 1'b0;
      out_cnt_d  = 2'd0;
    end else if (pop) begin
      if (out_cnt_q == 2'd2) begin
        dout_d = skid_q;
        if (inflight_q) begin
          skid_d    = ram_q1;
          out_cnt_d = 2'd2;
        end else begin
          out_cnt_d = 2'd1;
        end
      end else if (inflight_q) begin
        dout_d    = ram_q1;
        out_cnt_d = 2'd1;
      end else begin
        out_cnt_d = 2'd0;
      end
    end else if (inflight_q) begin
      // The fetch guard keeps out_cnt below 2 whenever a word is in flight
      if (out_cnt_q == 2'd0) begin
        dout_d    = ram_q1;
        out_cnt_d = 2'd1;
      end else begin
        skid_d    = ram_q1;
        out_cnt_d = 2'd2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      out_cnt_q  <= 2'd0;
      dout_q     <= '0;
      skid_q     <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      out_cnt_q  <= out_cnt_d;
      dout_q     <= dout_d;
      skid_q     <= skid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

endmodule

// File: tb/tb_jtframe_ram_fifo_ctl.sv
// tb/tb_jtframe_ram_fifo_ctl.sv - self-checking bench for jtframe_ram_fifo_ctl with a queue reference model
module tb_jtframe_ram_fifo_ctl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] din = '0;
  logic          wr = 1'b0;
  logic          full;
  logic          rd = 1'b0;
  logic [DW-1:0] dout;
  logic          empty;
  logic [AW+1:0] level;
  logic          ovf, unf;
  logic [AW-1:0] ram_addr0, ram_addr1;
  logic [DW-1:0] ram_data0;
  logic          ram_we0;
  logic [DW-1:0] ram_q1 = '0;

  logic [DW-1:0] mem [DEPTH];

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] model_q[$];
  logic exp_ovf = 1'b0;
  logic exp_unf = 1'b0;
  int pushes = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we0) mem[ram_addr0] <= ram_data0;
    ram_q1 <= mem[ram_addr1];
  end

  jtframe_ram_fifo_ctl #(.dw(DW), .aw(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .din(din), .wr(wr), .full(full),
    .rd(rd), .dout(dout), .empty(empty), .level(level), .ovf(ovf), .unf(unf),
    .ram_addr0(ram_addr0), .ram_data0(ram_data0), .ram_we0(ram_we0),
    .ram_addr1(ram_addr1), .ram_q1(ram_q1)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock cycle: inputs applied here take effect at the next edge; the model
  // tracks accepted words in order and the count of words held.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    logic e_s, f_s;
    logic [DW-1:0] d_s, exp_w;
    int lv;
    e_s = empty; f_s = full; d_s = dout;
    wr = w; din = d; rd = r; flush = f;
    #1;
    vectors++;
    if (ram_we0 !== (w && !f_s && !f)) begin
      miscompares++;
      $display("FAIL ram_we0: got %0b expected %0b", ram_we0, (w && !f_s && !f));
    end
    if (f) begin
      model_q.delete();
    end else begin
      if (r && !e_s) begin
        vectors++;
        if (model_q.size() == 0) begin
          miscompares++;
          $display("FAIL pop_extra: got word %0h expected no word", d_s);
        end else begin
          exp_w = model_q.pop_front();
          if (d_s !== exp_w) begin
            miscompares++;
            $display("FAIL pop_data: got %0h expected %0h", d_s, exp_w);
          end
        end
      end
      if (w && !f_s) begin
        model_q.push_back(d);
        pushes++;
      end
      if (w && f_s) exp_ovf = 1'b1;
      if (r && e_s) exp_unf = 1'b1;
    end
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0;
    lv = model_q.size();
    vectors++;
    if (level !== lv[AW+1:0]) begin
      miscompares++;
      $display("FAIL level: got %0d expected %0d", level, lv);
    end
    vectors++;
    if (ovf !== exp_ovf || unf !== exp_unf) begin
      miscompares++;
      $display("FAIL sticky: got ovf=%0b unf=%0b expected ovf=%0b unf=%0b", ovf, unf, exp_ovf, exp_unf);
    end
    if (lv == 0) begin
      vectors++;
      if (empty !== 1'b1) begin
        miscompares++;
        $display("FAIL empty_when_none: got %0b expected 1", empty);
      end
    end
    if (lv < DEPTH) begin
      vectors++;
      if (full !== 1'b0) begin
        miscompares++;
        $display("FAIL full_low_level: got %0b expected 0 at level %0d", full, lv);
      end
    end
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (model_q.size() > 0 && n < bound) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    vectors++;
    if (model_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d words left expected 0", model_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (empty !== 1'b1 || full !== 1'b0 || level !== '0 || dout !== '0 || ovf !== 1'b0 || unf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got empty=%0b full=%0b level=%0d dout=%0h ovf=%0b unf=%0b expected 1 0 0 0 0 0",
               empty, full, level, dout, ovf, unf);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i + 1), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (empty !== 1'b1 || full !== 1'b0 || level !== '0 || dout !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got empty=%0b full=%0b level=%0d dout=%0h expected 1 0 0 0",
               empty, full, level, dout);
    end
    model_q.delete();
    exp_ovf = 1'b0; exp_unf = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    for (int c = 1; c <= 2; c++) begin
      vectors++;
      if (empty !== 1'b1) begin
        miscompares++;
        $display("FAIL latency_early: got empty=%0b expected 1 in cycle %0d", empty, c);
      end
      cycle(1'b0, '0, 1'b0, 1'b0);
    end
    vectors++;
    if (empty !== 1'b0 || dout !== 8'hA5) begin
      miscompares++;
      $display("FAIL latency_3: got empty=%0b dout=%0h expected 0 a5", empty, dout);
    end
    drain(10);
  endtask

  task automatic test_underflow();
    logic [DW-1:0] held;
    held = dout;
    cycle(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (unf !== 1'b1 || dout !== held) begin
      miscompares++;
      $display("FAIL underflow: got unf=%0b dout=%0h expected 1 %0h", unf, dout, held);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 18; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 16) begin
        vectors++;
        if (full !== 1'b0) begin
          miscompares++;
          $display("FAIL full_17: got %0b expected 0", full);
        end
      end
    end
    vectors++;
    if (full !== 1'b1 || level !== 6'd18) begin
      miscompares++;
      $display("FAIL full_18: got full=%0b level=%0d expected 1 18", full, level);
    end
    cycle(1'b1, 8'h12, 1'b0, 1'b0);
    vectors++;
    if (ovf !== 1'b1 || level !== 6'd18) begin
      miscompares++;
      $display("FAIL overflow: got ovf=%0b level=%0d expected 1 18", ovf, level);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (full !== 1'b0) begin
      miscompares++;
      $display("FAIL full_after_read: got %0b expected 0", full);
    end
    drain(40);
    vectors++;
    if (empty !== 1'b1) begin
      miscompares++;
      $display("FAIL drained_empty: got %0b expected 1", empty);
    end
  endtask

  task automatic test_flush();
    logic ovf_before;
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    ovf_before = exp_ovf;
    cycle(1'b1, 8'h77, 1'b0, 1'b1);
    vectors++;
    if (empty !== 1'b1 || level !== '0 || ovf !== ovf_before) begin
      miscompares++;
      $display("FAIL flush: got empty=%0b level=%0d ovf=%0b expected 1 0 %0b", empty, level, ovf, ovf_before);
    end
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b0);
    vectors++;
    if (empty !== 1'b0 || dout !== 8'h5A) begin
      miscompares++;
      $display("FAIL after_flush: got empty=%0b dout=%0h expected 0 5a", empty, dout);
    end
    drain(10);
  endtask

  task automatic test_skid();
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    repeat (4) cycle(1'b0, '0, 1'b0, 1'b0);
    vectors++;
    if (empty !== 1'b0 || level !== 6'd6) begin
      miscompares++;
      $display("FAIL skid_fill: got empty=%0b level=%0d expected 0 6", empty, level);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if (dout !== model_q[0]) begin
      miscompares++;
      $display("FAIL skid_next: got %0h expected %0h", dout, model_q[0]);
    end
    cycle(1'b0, '0, 1'b0, 1'b0);
    vectors++;
    if (dout !== model_q[0] || level !== 6'd5) begin
      miscompares++;
      $display("FAIL skid_hold: got dout=%0h level=%0d expected %0h 5", dout, level, model_q[0]);
    end
    drain(20);
  endtask

  task automatic test_back_to_back();
    int gaps = 0;
    int early = 0;
    for (int i = 0; i < 100; i++) begin
      if (i < 3 && empty !== 1'b1) early++;
      if (i >= 3 && empty !== 1'b0) gaps++;
      cycle(1'b1, 8'(i + 8'h40), 1'b1, 1'b0);
    end
    vectors++;
    if (gaps != 0 || early != 0) begin
      miscompares++;
      $display("FAIL streaming: got gaps=%0d early=%0d expected 0 0", gaps, early);
    end
    drain(10);
  endtask

  task automatic test_wrap();
    int start = pushes;
    int n = 0;
    while ((pushes - start < 40 || model_q.size() > 0) && n < 2000) begin
      cycle((pushes - start < 40) && ($urandom_range(0, 1) == 1), 8'($urandom),
            ($urandom_range(0, 2) == 0), 1'b0);
      n++;
    end
    vectors++;
    if (pushes - start < 40 || model_q.size() != 0) begin
      miscompares++;
      $display("FAIL wrap_timeout: got %0d pushed %0d left expected 40 0", pushes - start, model_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_underflow();
    test_fill_drain();
    test_flush();
    test_skid();
    test_back_to_back();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
